// File: rtl/core_task_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_task_loader_pkg
// Description : Shared widths, derived sizes and FSM encoding for the per-core
//               task loader and its frame buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package core_task_loader_pkg;

    // Default geometry of the scheduler broadcast and the core interface
    localparam int c_NUM_CORES  = 4;
    localparam int c_FRAME_W    = 128;
    localparam int c_INSN_W     = 16;
    localparam int c_REG_W      = 8;
    localparam int c_BUF_FRAMES = 4;

    // Derived sizes for the default geometry
    localparam int c_INSNS_PER_FRAME = c_FRAME_W / c_INSN_W;
    localparam int c_ADDR_W          = $clog2(c_BUF_FRAMES * c_INSNS_PER_FRAME);

    // Loader sequencing states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    // Instruction-index width for an arbitrary geometry
    function automatic int calc_addr_w(input int buf_frames, input int frame_w,
                                       input int insn_w);
        return $clog2(buf_frames * (frame_w / insn_w));
    endfunction

endpackage : core_task_loader_pkg
`default_nettype wire

// File: rtl/core_task_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : core_task_loader_if
// Description : Scheduler broadcast plus core-side fetch/control signals seen
//               by one task loader. The loader uses the slave view; the
//               scheduler/core environment uses the master view.
// Revision    : 1.0 - initial release
// ============================================================================
interface core_task_loader_if
    import core_task_loader_pkg::*;
#(
    parameter int NUM_CORES  = c_NUM_CORES,
    parameter int FRAME_W    = c_FRAME_W,
    parameter int INSN_W     = c_INSN_W,
    parameter int REG_W      = c_REG_W,
    parameter int BUF_FRAMES = c_BUF_FRAMES
);
    localparam int c_IF_ADDR_W = calc_addr_w(BUF_FRAMES, FRAME_W, INSN_W);

    // Scheduler side
    logic [NUM_CORES-1:0]       Start;
    logic [FRAME_W-1:0]         Insn_Data;
    logic [NUM_CORES-1:0]       Init_R0_Vect;
    logic [NUM_CORES*REG_W-1:0] Init_R0;
    logic                       Ready;

    // Core side
    logic                       run;
    logic                       r0_we;
    logic [REG_W-1:0]           r0_data;
    logic [c_IF_ADDR_W-1:0]     fetch_addr;
    logic [INSN_W-1:0]          fetch_insn;
    logic                       halt;
    logic                       err;

    modport slave (
        input  Start, Insn_Data, Init_R0_Vect, Init_R0, fetch_addr, halt,
        output Ready, run, r0_we, r0_data, fetch_insn, err
    );

    modport master (
        output Start, Insn_Data, Init_R0_Vect, Init_R0, fetch_addr, halt,
        input  Ready, run, r0_we, r0_data, fetch_insn, err
    );

endinterface : core_task_loader_if
`default_nettype wire

// File: rtl/core_task_loader_frame_buf.sv
`default_nettype none
// ============================================================================
// Module      : core_task_loader_frame_buf
// Description : BUF_FRAMES x FRAME_W frame store with a full-frame write port
//               and a registered INSN_W-lane read port. Reads of words in
//               frames not yet written for this task return zero (NOP).
// Revision    : 1.0 - initial release
// ============================================================================
module core_task_loader_frame_buf #(
    parameter int BUF_FRAMES = 4,
    parameter int FRAME_W    = 128,
    parameter int INSN_W     = 16
) (
    input  wire logic                                            clk,
    input  wire logic                                            rst,
    input  wire logic                                            i_we,
    input  wire logic [$clog2(BUF_FRAMES)-1:0]                   i_waddr,
    input  wire logic [FRAME_W-1:0]                              i_wdata,
    input  wire logic                                            i_re,
    input  wire logic [$clog2(BUF_FRAMES*(FRAME_W/INSN_W))-1:0]  i_raddr,
    input  wire logic [$clog2(BUF_FRAMES):0]                     i_frames,
    output logic      [INSN_W-1:0]                               o_rdata
);
    // Lane and frame fields of an instruction index (needs >=2 lanes, >=2 frames)
    localparam int c_IPF    = FRAME_W / INSN_W;
    localparam int c_LANE_W = $clog2(c_IPF);
    localparam int c_FIDX_W = $clog2(BUF_FRAMES);

    logic [FRAME_W-1:0]  r_mem [BUF_FRAMES];
    logic [INSN_W-1:0]   r_rdata;

    logic [c_FIDX_W-1:0] w_rframe;
    logic [c_LANE_W-1:0] w_rlane;
    logic                w_in_range;
    logic [INSN_W-1:0]   w_lane_word;

    assign w_rframe    = i_raddr[c_LANE_W +: c_FIDX_W];
    assign w_rlane     = i_raddr[c_LANE_W-1:0];
    // Whole frames are always written, so a frame-granular check is exact
    assign w_in_range  = ({1'b0, w_rframe} < i_frames);
    assign w_lane_word = r_mem[w_rframe][w_rlane*INSN_W +: INSN_W];
    assign o_rdata     = r_rdata;

    // Frame write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered lane read with out-of-range words forced to NOP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= w_in_range ? w_lane_word : '0;
        end
    end

endmodule : core_task_loader_frame_buf
`default_nettype wire

// File: rtl/core_task_loader.sv
`default_nettype none
// ============================================================================
// Module      : core_task_loader
// Description : Per-core receiver below the task scheduler. Captures a burst
//               of instruction frames into a local buffer, latches this
//               core's initial R0, releases the core to run while serving
//               instruction fetches, and reports Ready back to the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module core_task_loader
    import core_task_loader_pkg::*;
#(
    parameter int CORE_ID    = 0,
    parameter int NUM_CORES  = c_NUM_CORES,
    parameter int FRAME_W    = c_FRAME_W,
    parameter int INSN_W     = c_INSN_W,
    parameter int REG_W      = c_REG_W,
    parameter int BUF_FRAMES = c_BUF_FRAMES
) (
    input  wire logic          clk,
    input  wire logic          reset,
    core_task_loader_if.slave  bus
);
    localparam int                c_FIDX_W   = $clog2(BUF_FRAMES);
    localparam int                c_PTR_W    = c_FIDX_W + 1;
    localparam logic [c_PTR_W-1:0] c_BUF_FULL = c_PTR_W'(BUF_FRAMES);

    // Registered state
    state_t              r_state;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic                r_ready;
    logic                r_run;
    logic                r_r0_we;
    logic [REG_W-1:0]    r_r0_data;
    logic                r_r0_pending;
    logic [REG_W-1:0]    r_r0_val;
    logic                r_err;

    // Next-state values
    state_t              w_state_nxt;
    logic [c_PTR_W-1:0]  w_wr_ptr_nxt;
    logic                w_ready_nxt;
    logic                w_run_nxt;
    logic                w_r0_we_nxt;
    logic [REG_W-1:0]    w_r0_data_nxt;
    logic                w_r0_pending_nxt;
    logic [REG_W-1:0]    w_r0_val_nxt;
    logic                w_err_nxt;

    // Frame buffer controls
    logic                w_buf_we;
    logic [c_FIDX_W-1:0] w_buf_waddr;
    logic [INSN_W-1:0]   w_fetch_insn;

    // This core's view of the scheduler broadcast
    logic                w_start;
    logic                w_r0_sel;
    logic [REG_W-1:0]    w_r0_slice;
    logic                w_unused_sched;

    assign w_start    = bus.Start[CORE_ID];
    assign w_r0_sel   = bus.Init_R0_Vect[CORE_ID];
    assign w_r0_slice = bus.Init_R0[CORE_ID*REG_W +: REG_W];
    // Other cores' lanes of the broadcast are intentionally ignored
    assign w_unused_sched = ^{bus.Start, bus.Init_R0_Vect, bus.Init_R0};

    // State and output registers; reset aborts any task in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_ready      <= 1'b1;
            r_run        <= 1'b0;
            r_r0_we      <= 1'b0;
            r_r0_data    <= '0;
            r_r0_pending <= 1'b0;
            r_r0_val     <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_ready      <= w_ready_nxt;
            r_run        <= w_run_nxt;
            r_r0_we      <= w_r0_we_nxt;
            r_r0_data    <= w_r0_data_nxt;
            r_r0_pending <= w_r0_pending_nxt;
            r_r0_val     <= w_r0_val_nxt;
            r_err        <= w_err_nxt;
        end
    end

    // Next-state, buffer-write and output decode
    always_comb begin
        w_state_nxt      = r_state;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_ready_nxt      = r_ready;
        w_run_nxt        = r_run;
        w_r0_we_nxt      = 1'b0;
        w_r0_data_nxt    = r_r0_data;
        w_r0_pending_nxt = r_r0_pending;
        w_r0_val_nxt     = r_r0_val;
        w_err_nxt        = r_err;
        w_buf_we         = 1'b0;
        w_buf_waddr      = r_wr_ptr[c_FIDX_W-1:0];

        case (r_state)
            S_IDLE: begin
                w_ready_nxt = 1'b1;
                w_run_nxt   = 1'b0;
                if (w_start) begin
                    // First frame of a burst; R0 request is sampled only here
                    w_buf_we         = 1'b1;
                    w_buf_waddr      = '0;
                    w_wr_ptr_nxt     = c_PTR_W'(1);
                    w_r0_pending_nxt = w_r0_sel;
                    w_r0_val_nxt     = w_r0_slice;
                    w_state_nxt      = S_LOAD;
                end
            end

            S_LOAD: begin
                if (w_start) begin
                    if (r_wr_ptr == c_BUF_FULL) begin
                        // Buffer full: drop the frame and flag it
                        w_err_nxt = 1'b1;
                    end else begin
                        w_buf_we     = 1'b1;
                        w_wr_ptr_nxt = r_wr_ptr + c_PTR_W'(1);
                    end
                end else begin
                    // Burst ended: hand the core its program
                    w_state_nxt = S_RUN;
                    w_ready_nxt = 1'b0;
                    w_run_nxt   = 1'b1;
                    if (r_r0_pending) begin
                        w_r0_we_nxt   = 1'b1;
                        w_r0_data_nxt = r_r0_val;
                    end
                end
            end

            S_RUN: begin
                // A new burst while busy is never accepted
                if (w_start) begin
                    w_err_nxt = 1'b1;
                end
                if (bus.halt) begin
                    w_state_nxt  = S_IDLE;
                    w_run_nxt    = 1'b0;
                    w_ready_nxt  = 1'b1;
                    w_wr_ptr_nxt = '0;
                end
            end

            default: begin
                w_state_nxt  = S_IDLE;
                w_run_nxt    = 1'b0;
                w_ready_nxt  = 1'b1;
                w_wr_ptr_nxt = '0;
            end
        endcase
    end

    core_task_loader_frame_buf #(
        .BUF_FRAMES (BUF_FRAMES),
        .FRAME_W    (FRAME_W),
        .INSN_W     (INSN_W)
    ) u_frame_buf (
        .clk      (clk),
        .rst      (reset),
        .i_we     (w_buf_we),
        .i_waddr  (w_buf_waddr),
        .i_wdata  (bus.Insn_Data),
        .i_re     (r_state == S_RUN),
        .i_raddr  (bus.fetch_addr),
        .i_frames (r_wr_ptr),
        .o_rdata  (w_fetch_insn)
    );

    assign bus.Ready      = r_ready;
    assign bus.run        = r_run;
    assign bus.r0_we      = r_r0_we;
    assign bus.r0_data    = r_r0_data;
    assign bus.fetch_insn = w_fetch_insn;
    assign bus.err        = r_err;

endmodule : core_task_loader
`default_nettype wire

// File: tb/tb_core_task_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_task_loader
// Description : Directed self-checking bench for core_task_loader (CORE_ID=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_task_loader;

    localparam int c_NUM_CORES  = 4;
    localparam int c_FRAME_W    = 128;
    localparam int c_INSN_W     = 16;
    localparam int c_REG_W      = 8;
    localparam int c_BUF_FRAMES = 4;

    logic clk = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    core_task_loader_if #(
        .NUM_CORES  (c_NUM_CORES),
        .FRAME_W    (c_FRAME_W),
        .INSN_W     (c_INSN_W),
        .REG_W      (c_REG_W),
        .BUF_FRAMES (c_BUF_FRAMES)
    ) u_if ();

    core_task_loader #(
        .CORE_ID    (1),
        .NUM_CORES  (c_NUM_CORES),
        .FRAME_W    (c_FRAME_W),
        .INSN_W     (c_INSN_W),
        .REG_W      (c_REG_W),
        .BUF_FRAMES (c_BUF_FRAMES)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    task automatic check_val(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame f carries word 16'hF<f>0<lane> in each lane
    function automatic logic [127:0] mkframe(input logic [3:0] f);
        logic [127:0] fr;
        for (int l = 0; l < 8; l++) begin
            fr[l*16 +: 16] = {4'hF, f, 4'h0, 4'(l)};
        end
        return fr;
    endfunction

    initial begin
        reset             = 1'b1;
        u_if.Start        = '0;
        u_if.Insn_Data    = '0;
        u_if.Init_R0_Vect = '0;
        u_if.Init_R0      = '0;
        u_if.fetch_addr   = '0;
        u_if.halt         = 1'b0;

        // ---------------- reset state ----------------
        @(negedge clk);
        @(negedge clk);
        check_val("rst_ready",   u_if.Ready,      1);
        check_val("rst_run",     u_if.run,        0);
        check_val("rst_r0_we",   u_if.r0_we,      0);
        check_val("rst_r0_data", u_if.r0_data,    0);
        check_val("rst_fetch",   u_if.fetch_insn, 0);
        check_val("rst_err",     u_if.err,        0);
        reset = 1'b0;

        // ---------------- single-frame task with R0 ----------------
        u_if.Start        = 4'b0010;
        u_if.Insn_Data    = {96'h0, 16'h0007, 16'h0003};
        u_if.Init_R0_Vect = 4'b0010;
        u_if.Init_R0      = 32'h11_22_A5_33;
        @(negedge clk);
        check_val("a_load_ready", u_if.Ready, 1);
        check_val("a_load_run",   u_if.run,   0);
        // R0 inputs changing after the first cycle must not matter
        u_if.Start        = '0;
        u_if.Init_R0_Vect = 4'b1111;
        u_if.Init_R0      = 32'hFFFF_FFFF;
        u_if.Insn_Data    = '1;
        @(negedge clk);
        check_val("a_run_ready", u_if.Ready,   0);
        check_val("a_run_run",   u_if.run,     1);
        check_val("a_r0_we",     u_if.r0_we,   1);
        check_val("a_r0_data",   u_if.r0_data, 8'hA5);
        u_if.fetch_addr = 5'd0;
        @(negedge clk);
        check_val("a_r0_we_off", u_if.r0_we,      0);
        check_val("a_fetch0",    u_if.fetch_insn, 16'h0003);
        u_if.fetch_addr = 5'd1;
        @(negedge clk);
        check_val("a_fetch1",    u_if.fetch_insn, 16'h0007);
        u_if.fetch_addr = 5'd8;
        @(negedge clk);
        check_val("a_fetch8_nop", u_if.fetch_insn, 16'h0000);
        u_if.halt         = 1'b1;
        u_if.Init_R0_Vect = '0;
        u_if.Init_R0      = '0;
        u_if.Insn_Data    = '0;
        @(negedge clk);
        u_if.halt = 1'b0;
        check_val("a_halt_ready", u_if.Ready, 1);
        check_val("a_halt_run",   u_if.run,   0);
        check_val("a_err",        u_if.err,   0);

        // ---------------- other cores only, halt while idle ----------------
        u_if.Start        = 4'b1101;
        u_if.Insn_Data    = '1;
        u_if.Init_R0_Vect = 4'b1101;
        u_if.halt         = 1'b1;
        @(negedge clk);
        check_val("o_ready0", u_if.Ready, 1);
        check_val("o_run0",   u_if.run,   0);
        u_if.Start = '0;
        u_if.halt  = 1'b0;
        @(negedge clk);
        check_val("o_ready1", u_if.Ready, 1);
        check_val("o_run1",   u_if.run,   0);
        check_val("o_r0_we",  u_if.r0_we, 0);
        check_val("o_err",    u_if.err,   0);

        // ---------------- three-frame burst, no R0 ----------------
        u_if.Init_R0_Vect = 4'b1101;
        u_if.Init_R0      = 32'h12_34_99_56;
        for (int i = 0; i < 3; i++) begin
            u_if.Start     = 4'b0010;
            u_if.Insn_Data = mkframe(4'(i));
            @(negedge clk);
            check_val("b_load_ready", u_if.Ready, 1);
            check_val("b_load_r0_we", u_if.r0_we, 0);
        end
        u_if.Start     = '0;
        u_if.Insn_Data = '0;
        @(negedge clk);
        check_val("b_run_ready", u_if.Ready, 0);
        check_val("b_run_run",   u_if.run,   1);
        check_val("b_r0_we0",    u_if.r0_we, 0);
        u_if.fetch_addr = 5'd16;
        @(negedge clk);
        check_val("b_r0_we1",    u_if.r0_we,      0);
        check_val("b_fetch16",   u_if.fetch_insn, 16'hF200);
        u_if.fetch_addr = 5'd24;
        @(negedge clk);
        check_val("b_fetch24",   u_if.fetch_insn, 16'h0000);
        u_if.fetch_addr = 5'd13;
        @(negedge clk);
        check_val("b_fetch13",   u_if.fetch_insn, 16'hF105);
        u_if.fetch_addr = 5'd7;
        @(negedge clk);
        check_val("b_fetch7",    u_if.fetch_insn, 16'hF007);
        u_if.halt = 1'b1;
        @(negedge clk);
        u_if.halt = 1'b0;
        check_val("b_halt_ready", u_if.Ready, 1);

        // ---------------- overflow: five frames into four slots ----------------
        u_if.Init_R0_Vect = 4'b0010;
        u_if.Init_R0      = 32'h00_00_5C_00;
        for (int i = 0; i < 5; i++) begin
            u_if.Start     = 4'b0010;
            u_if.Insn_Data = mkframe(4'(8 + i));
            @(negedge clk);
            check_val("d_load_ready", u_if.Ready, 1);
            check_val("d_load_err",   u_if.err,   (i == 4) ? 1 : 0);
        end
        u_if.Start     = '0;
        u_if.Insn_Data = '0;
        @(negedge clk);
        check_val("d_run_run",   u_if.run,     1);
        check_val("d_run_ready", u_if.Ready,   0);
        check_val("d_r0_we",     u_if.r0_we,   1);
        check_val("d_r0_data",   u_if.r0_data, 8'h5C);
        check_val("d_err",       u_if.err,     1);
        u_if.fetch_addr = 5'd0;
        @(negedge clk);
        check_val("d_fetch0",  u_if.fetch_insn, 16'hF800);
        u_if.fetch_addr = 5'd31;
        @(negedge clk);
        check_val("d_fetch31", u_if.fetch_insn, 16'hFB07);
        u_if.fetch_addr = 5'd24;
        @(negedge clk);
        check_val("d_fetch24", u_if.fetch_insn, 16'hFB00);
        u_if.fetch_addr = 5'd9;
        @(negedge clk);
        check_val("d_fetch9",  u_if.fetch_insn, 16'hF901);

        // ---------------- asynchronous reset while running ----------------
        #2 reset = 1'b1;
        #1;
        check_val("r_async_ready", u_if.Ready, 1);
        check_val("r_async_run",   u_if.run,   0);
        check_val("r_async_err",   u_if.err,   0);
        check_val("r_async_r0_we", u_if.r0_we, 0);
        @(negedge clk);
        reset = 1'b0;
        check_val("r_r0_data", u_if.r0_data,    0);
        check_val("r_fetch",   u_if.fetch_insn, 0);

        // ---------------- halt/Start collision, then fresh task ----------------
        u_if.Start        = 4'b0010;
        u_if.Insn_Data    = mkframe(4'd6);
        u_if.Init_R0_Vect = '0;
        @(negedge clk);
        u_if.Start = '0;
        @(negedge clk);
        check_val("e_run", u_if.run, 1);
        u_if.Start     = 4'b0010;
        u_if.Insn_Data = '1;
        u_if.halt      = 1'b1;
        @(negedge clk);
        u_if.Start = '0;
        u_if.halt  = 1'b0;
        check_val("e_col_ready", u_if.Ready, 1);
        check_val("e_col_run",   u_if.run,   0);
        check_val("e_col_err",   u_if.err,   1);
        u_if.Start        = 4'b0010;
        u_if.Insn_Data    = mkframe(4'd5);
        u_if.Init_R0_Vect = 4'b0010;
        u_if.Init_R0      = 32'h00_00_3C_00;
        @(negedge clk);
        check_val("e_new_load", u_if.Ready, 1);
        u_if.Start = '0;
        @(negedge clk);
        check_val("e_new_run",     u_if.run,     1);
        check_val("e_new_r0_we",   u_if.r0_we,   1);
        check_val("e_new_r0_data", u_if.r0_data, 8'h3C);
        u_if.fetch_addr = 5'd2;
        @(negedge clk);
        check_val("e_fetch2", u_if.fetch_insn, 16'hF502);
        u_if.fetch_addr = 5'd8;
        @(negedge clk);
        check_val("e_fetch8", u_if.fetch_insn, 16'h0000);
        check_val("e_err",    u_if.err,        1);
        u_if.halt = 1'b1;
        @(negedge clk);
        u_if.halt = 1'b0;
        check_val("e_end_ready", u_if.Ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_core_task_loader
`default_nettype wire
